fifo_sync_fwft: RTL

FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

---
 rtl/fifo_sync_fwft.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_fwft.sv
// Synchronous FIFO on one block RAM, optional first-word-fall-through output stage.
// Define FIFO_SYNC_FWFT_ERR_FLAGS_EN to add the sticky wr_overflow / rd_underflow outputs.
module fifo_sync_fwft #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 9,
    parameter int FWFT_MODE       = 1,
    parameter int ALMOST_FULL_TH  = 460,
    parameter int ALMOST_EMPTY_TH = 51
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_dv,
    input  logic [DATA_WIDTH-1:0] wr_DATA,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_DATA,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
`ifdef FIFO_SYNC_FWFT_ERR_FLAGS_EN
    output logic                  wr_overflow,
    output logic                  rd_underflow,
`endif
    output logic [ADDR_WIDTH:0]   level
);

    localparam int            LW      = ADDR_WIDTH + 1;
    localparam int            DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_TH   = LW'(ALMOST_FULL_TH);
    localparam logic [LW-1:0] AE_TH   = LW'(ALMOST_EMPTY_TH);
    localparam bit            FWFT    = (FWFT_MODE != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [LW-1:0]         ram_cnt;
    logic                  wr_acc, pop_acc, ram_rd;

    assign wr_full         = (level_q == DEPTH_L);
    assign wr_almost_full  = (level_q >= AF_TH);
    assign rd_almost_empty = (level_q <= AE_TH);
    assign rd_empty        = FWFT ? !valid_q : (level_q == '0);
    assign rd_valid        = valid_q;
    assign rd_DATA         = rd_data_q;
    assign level           = level_q;

    // In FWFT mode the RAM output register is the output stage; it is refilled
    // on the same edge as a pop so back-to-back reads see no bubble.
    always_comb begin
        wr_acc  = wr_dv && !wr_full;
        pop_acc = rd_en && !rd_empty;
        ram_cnt = level_q;
        ram_rd  = pop_acc;
        valid_d = pop_acc;
        if (FWFT) begin
            ram_cnt = level_q - LW'(valid_q);
            ram_rd  = (ram_cnt != '0) && (!valid_q || pop_acc);
            valid_d = ram_rd || (valid_q && !pop_acc);
        end
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(ram_rd);
        level_d  = level_q + LW'(wr_acc) - LW'(pop_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr_q] <= wr_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else if (clr) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            if (ram_rd) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

`ifdef FIFO_SYNC_FWFT_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_dv && wr_full) ovf_q <= 1'b1;
            if (rd_en && rd_empty) udf_q <= 1'b1;
        end
    end

    assign wr_overflow  = ovf_q;
    assign rd_underflow = udf_q;
`endif

endmodule
